// File: rtl/crc_sched_pkg.sv
// Shared types and constants for the frame scheduler around the serial CRC engine.
// Optional serial CRC unload is enabled with CRC_SER_OUT_EN.
package crc_sched_pkg;

    localparam int NUM_REQ = 2;
    localparam int CRC_W   = 8;
    localparam int CNT_W   = 3;

    localparam logic [CRC_W-1:0] DEF_SEED = 8'hD8;
    localparam logic [CRC_W-1:0] DEF_TAPS = 8'hC4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        UNLOAD,
        DONE
    } state_t;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit-per-clock LFSR register: right shift with TAPS feedback, synchronous SEED load.
module crc_lfsr_step #(
    parameter int             WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 8'hD8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hC4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             data_bit_i,
    output logic [WIDTH-1:0] lfsr_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic             fb;

    always_comb begin
        fb     = lfsr_q[0] ^ data_bit_i;
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (en_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (fb ? TAPS : '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/crc_frame_sched.sv
// Round-robin whole-frame arbiter feeding two byte streams LSB-first through a private CRC LFSR.
// Define CRC_SER_OUT_EN to add the 8-cycle serial CRC unload (crc_bit/crc_bit_vld).
module crc_frame_sched
    import crc_sched_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = DEF_SEED,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS
) (
    input  logic                     CLK,
    input  logic                     RST,
    // valid/ready: a byte transfers on a rising edge where req_valid[i] & req_ready[i].
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     busy,
    output logic [WIDTH-1:0]         crc_out,
    output logic                     crc_src,
    output logic                     crc_valid,
`ifdef CRC_SER_OUT_EN
    output logic                     crc_bit,
    output logic                     crc_bit_vld,
`endif
    output state_t                   dbg_state
);

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               rr_q, rr_d;
    logic [WIDTH-1:0]   byte_q, byte_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   crc_q, crc_d;
    logic               src_q, src_d;
    logic               lfsr_load;
    logic               lfsr_en;
    logic [WIDTH-1:0]   lfsr;

    crc_lfsr_step #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk_i      (CLK),
        .rst_n_i    (RST),
        .load_i     (lfsr_load),
        .en_i       (lfsr_en),
        .data_bit_i (byte_q[cnt_q]),
        .lfsr_o     (lfsr)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        byte_d    = byte_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        src_d     = src_q;
        req_ready = '0;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        crc_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d   = (&req_valid) ? rr_q : req_valid[1];
                    lfsr_load = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                req_ready[grant_q] = 1'b1;
                if (req_valid[grant_q]) begin
                    byte_d  = grant_q ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
                    last_d  = req_last[grant_q];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                lfsr_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (&cnt_q) begin
`ifdef CRC_SER_OUT_EN
                    state_d = last_q ? UNLOAD : FETCH;
`else
                    state_d = last_q ? DONE : FETCH;
`endif
                end
            end
`ifdef CRC_SER_OUT_EN
            UNLOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                crc_valid = 1'b1;
                crc_d     = lfsr;
                src_d     = grant_q;
                rr_d      = ~grant_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            crc_q   <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            src_q   <= src_d;
        end
    end

    // The engine is frozen outside SHIFT, so during UNLOAD/DONE lfsr is the final CRC snapshot.
    assign crc_out   = (state_q == DONE) ? lfsr : crc_q;
    assign crc_src   = (state_q == DONE) ? grant_q : src_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

`ifdef CRC_SER_OUT_EN
    assign crc_bit     = lfsr[cnt_q];
    assign crc_bit_vld = (state_q == UNLOAD);
`endif

endmodule

// File: doc/crc_frame_sched.md
Name: crc_frame_sched

Overview:
- Frame-level scheduler for the team's 8-bit serial CRC datapath.
- Arbitrates whole frames between two byte-stream requesters, round-robin.
- Feeds each granted frame LSB-first, one bit per clock, through a private LFSR engine, reseeding the engine for every frame.
- Returns the final CRC byte tagged with the source requester; sits between the packet-assembly logic and the TX framer.

Parameters:
- WIDTH, 8, LFSR and data byte width.
- SEED, 8'hD8, LFSR value loaded at the start of every frame and on reset.
- TAPS, 8'hC4, feedback XOR mask. Next state = (lfsr >> 1) ^ (fb ? TAPS : 0), where fb = lfsr[0] ^ data_bit.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester byte valid.
- req_data  in  16  per-requester byte; bits [8i+7:8i] belong to requester i.
- req_last  in  2  per-requester last-byte-of-frame flag.
- req_ready  out  2  per-requester accept strobe.
- busy  out  1  high from grant until the DONE state has been exited.
- crc_out  out  WIDTH  final CRC of the most recent frame.
- crc_src  out  1  requester index of that frame.
- crc_valid  out  1  one-cycle pulse when crc_out/crc_src update.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous, active-low.
- Reset values: req_ready=0, busy=0, crc_out=0, crc_src=0, crc_valid=0, lfsr=SEED, rr pointer=0 (requester 0 wins first tie), state=IDLE.
- IDLE:
  - If any req_valid is high, grant a requester, load lfsr<=SEED, set busy=1, go to FETCH.
  - Tie: grant the requester the rr pointer favours. Single request: grant it.
- FETCH:
  - req_ready[grant]=1 combinationally; the other ready is 0.
  - On req_valid[grant] & ready: capture the byte and last flag, bit counter<=0, go to SHIFT.
  - If valid is low: wait indefinitely, no timeout.
- SHIFT:
  - 8 cycles; each cycle applies the LFSR update with data bit byte[cnt] (LSB first).
  - After cnt==7: if last, go to UNLOAD (feature on) or DONE; otherwise go to FETCH.
- DONE:
  - crc_out<=lfsr, crc_src<=grant, crc_valid=1 for exactly one cycle.
  - rr pointer<=~grant, busy=0, go to IDLE. The next grant can be in the cycle after DONE.
- Latency: frame of N bytes with no valid stalls = 1 (IDLE) + 9N + 1 (DONE) cycles, plus 8 with the optional feature.
- Non-granted requester: its valid is ignored and its ready stays 0 until the current frame completes. No frame interleaving.
- req_last is sampled only on the accepted byte. Minimum frame is 1 byte.
- RST asserted mid-frame: immediate return to reset values; the partial frame is discarded and no crc_valid is issued.
- crc_out/crc_src hold their value between DONE pulses.

Optional Feature:
- Macro: CRC_SER_OUT_EN.
- Defined:
  - Adds ports crc_bit (out, 1) and crc_bit_vld (out, 1).
  - Adds state UNLOAD between the last SHIFT and DONE: 8 cycles shifting lfsr right, driving crc_bit=lfsr[0] and crc_bit_vld=1.
  - DONE still reports the pre-unload CRC value, held in a snapshot register.
- Undefined: ports and UNLOAD absent; last SHIFT goes straight to DONE.

Decomposition:
- Package crc_sched_pkg:
  - state enum {IDLE, FETCH, SHIFT, UNLOAD, DONE}.
  - Default SEED and TAPS constants.
  - NUM_REQ=2.
  - Bit-counter width localparam (3).
- One sub-module: crc_lfsr_step.
  - Inputs: lfsr, data bit, enable, synchronous load.
  - Output: registered next-state LFSR with SEED load.
  - The scheduler owns the FSM, arbitration and handshake.

Test Plan:
- Single frame, requester 0, one byte 0x00 -> crc_valid after 10 cycles, crc_out=0x14, crc_src=0.
- Single frame, requester 1, one byte 0xFF -> crc_out=0x72, crc_src=1.
- Both valid in the same IDLE cycle after reset, one-byte frames 0x00 (req0) and 0xFF (req1) -> req0 served first (0x14, src 0), then req1 (0x72, src 1). req_ready[1] stays 0 throughout frame 0.
- Two-byte frame 0x00,0x00 with req_valid dropped 3 cycles before the second byte -> FETCH waits, total latency 22 cycles, CRC equals the unstalled run.
- RST pulsed during the 4th SHIFT cycle -> all outputs at reset values, no crc_valid; the next frame 0x00 yields 0x14.
- With CRC_SER_OUT_EN, byte 0x00 -> crc_bit_vld for 8 cycles with crc_bit sequence 0,0,1,0,1,0,0,0, then crc_valid with crc_out=0x14.
